l_key_loader: RTL

L_KEY_LOADER -- requirements
Module: l_key_loader

---
 rtl/l_key_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/l_key_loader.sv
// Loads a byte-addressed key into the word-addressed L array: clears c words,
// then folds key bytes b-1..0 into L[i/U] with rotate-left-by-8 plus byte add.
module l_key_loader #(
  parameter int B = 16,
  parameter int W = 32,
  localparam int U = W / 8,
  localparam int C = (B + U - 1) / U,
  localparam int C_length = (C > 1) ? $clog2(C) : 1,
  localparam int KL_W = $clog2(B + 1),
  localparam int KA_W = (B > 1) ? $clog2(B) : 1,
  localparam int CW = C_length + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KL_W-1:0]     key_len,
  output logic [KA_W-1:0]     key_address,
  input  logic [7:0]          key_sub_i,
  output logic [C_length-1:0] L_address,
  input  logic [W-1:0]        L_sub_i,
  output logic [W-1:0]        L_sub_i_prima,
  output logic                L_we,
  output logic [CW-1:0]       c_words,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_ADDR, READ_DATA, OPERATE_DATA, WRITE_DATA, FINISH
  } state_t;

  state_t state, state_next;

  logic [KL_W-1:0]     b_len;
  logic [CW-1:0]       c_cnt;
  logic [CW-1:0]       c_calc;
  logic [C_length-1:0] k;
  logic [KA_W-1:0]     i;
  logic                err_flag;
  logic                len_ok;
  logic [C_length-1:0] word_idx;

  logic [KA_W-1:0]     key_address_next;
  logic [C_length-1:0] L_address_next;
  logic [W-1:0]        L_sub_i_prima_next;
  logic                L_we_next;
  logic                busy_next;
  logic                done_next;
  logic                error_next;

  assign len_ok   = (key_len <= KL_W'(B));
  assign word_idx = C_length'(int'(i) / U);

  // An empty key still occupies one (cleared) word.
  always_comb begin
    c_calc = CW'((int'(key_len) + U - 1) / U);
    if (c_calc == '0) c_calc = CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (start) state_next = len_ok ? CLEAR : FINISH;
      CLEAR:        if ({1'b0, k} == c_cnt - CW'(1))
                      state_next = (b_len == '0) ? FINISH : WAIT_ADDR;
      WAIT_ADDR:    state_next = READ_DATA;
      READ_DATA:    state_next = OPERATE_DATA;
      OPERATE_DATA: state_next = WRITE_DATA;
      WRITE_DATA:   state_next = (i == '0) ? FINISH : WAIT_ADDR;
      FINISH:       state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_len    <= '0;
      c_cnt    <= '0;
      c_words  <= '0;
      k        <= '0;
      i        <= '0;
      err_flag <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        err_flag <= !len_ok;
        if (len_ok) begin
          b_len   <= key_len;
          c_cnt   <= c_calc;
          c_words <= c_calc;
          k       <= '0;
          i       <= KA_W'(key_len - KL_W'(1));
        end
      end
      if (state == CLEAR) k <= k + C_length'(1);
      if (state == WRITE_DATA && i != '0) i <= i - KA_W'(1);
    end
  end

  // Outputs are computed from the current state and registered, so every
  // output lags its state by one cycle; memory timing is planned around that.
  always_comb begin
    key_address_next   = key_address;
    L_address_next     = L_address;
    L_sub_i_prima_next = L_sub_i_prima;
    L_we_next          = 1'b0;
    busy_next          = 1'b0;
    done_next          = 1'b0;
    error_next         = 1'b0;
    case (state)
      CLEAR: begin
        L_address_next     = k;
        L_sub_i_prima_next = '0;
        L_we_next          = 1'b1;
        busy_next          = 1'b1;
      end
      WAIT_ADDR, READ_DATA, WRITE_DATA: begin
        key_address_next = i;
        L_address_next   = word_idx;
        busy_next        = 1'b1;
        L_we_next        = (state == WRITE_DATA);
      end
      OPERATE_DATA: begin
        key_address_next   = i;
        L_address_next     = word_idx;
        busy_next          = 1'b1;
        L_sub_i_prima_next = {L_sub_i[W-9:0], L_sub_i[W-1:W-8]}
                             + {{(W-8){1'b0}}, key_sub_i};
      end
      FINISH: begin
        done_next  = 1'b1;
        error_next = err_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_address   <= '0;
      L_address     <= '0;
      L_sub_i_prima <= '0;
      L_we          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      key_address   <= key_address_next;
      L_address     <= L_address_next;
      L_sub_i_prima <= L_sub_i_prima_next;
      L_we          <= L_we_next;
      busy          <= busy_next;
      done          <= done_next;
      error         <= error_next;
    end
  end

endmodule
